echo_delay: RTL and testbench

//  Parametrised multi-tap delay/echo engine for the mic audio path. Stores every

---
 rtl/echo_delay_pkg.sv | 24 ++
 rtl/dp_ram.sv | 34 +++
 rtl/echo_delay.sv | 267 ++++++++++++++++++++++++++
 tb/tb_echo_delay.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_delay_pkg.sv
// Shared types and constants for the echo_delay audio delay/echo engine.
// Contents:
//   SHIFT_WIDTH  width of each per-tap and feedback attenuation shift field
//   mode_t       processing mode selected per sample
//   state_t      sequencer states of the echo_delay control FSM
package echo_delay_pkg;

  localparam int SHIFT_WIDTH = 3;

  typedef enum logic [1:0] {
    DELAY    = 2'd0,
    MULTITAP = 2'd1,
    ECHO     = 2'd2,
    BYPASS   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one read port with a
// registered (1-cycle latency) output. Contents are not reset.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (sampled on the rising edge)
//   rd_data  read data, valid the cycle after rd_addr was presented
module dp_ram #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/echo_delay.sv
// Multi-tap delay / echo engine for the mic audio path. Every accepted sample
// is stored in a circular RAM; up to NUM_TAPS delayed copies are read back and
// combined according to the latched mode (DELAY, MULTITAP, ECHO, BYPASS).
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   sample_valid    strobe: mic_signal holds a new sample
//   mic_signal      input sample (unsigned)
//   mode            0 DELAY, 1 MULTITAP, 2 ECHO, 3 BYPASS
//   tap_en          per-tap enable (MULTITAP)
//   tap_offset      packed per-tap delay in samples, tap k at [k*AW +: AW]
//   tap_shift       packed per-tap right-shift attenuation
//   fb_shift        feedback attenuation shift (ECHO)
//   clr_overrun     clears the sticky overrun flag
//   delayed_signal  result sample, held until the next result
//   out_valid       one-cycle pulse when delayed_signal updates
//   busy            a sample is being processed; new strobes are dropped
//   overrun         sticky: a strobe arrived while busy
// Handshake: a strobe is accepted only on an edge where busy is low; the result
// appears with out_valid exactly NUM_TAPS+2 edges after that acceptance edge.
module echo_delay
  import echo_delay_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_TAPS      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sample_valid,
  input  logic [DATA_WIDTH-1:0]             mic_signal,
  input  logic [1:0]                        mode,
  input  logic [NUM_TAPS-1:0]               tap_en,
  input  logic [NUM_TAPS*ADDRESS_WIDTH-1:0] tap_offset,
  input  logic [NUM_TAPS*SHIFT_WIDTH-1:0]   tap_shift,
  input  logic [SHIFT_WIDTH-1:0]            fb_shift,
  input  logic                              clr_overrun,
  output logic [DATA_WIDTH-1:0]             delayed_signal,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int DEPTH  = 2**ADDRESS_WIDTH;
  localparam int FILL_W = ADDRESS_WIDTH + 1;
  localparam int TAP_IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int ACC_W  = DATA_WIDTH + $clog2(NUM_TAPS) + 1;
  localparam logic [TAP_IW-1:0]     LAST_TAP   = TAP_IW'(NUM_TAPS - 1);
  localparam logic [FILL_W-1:0]     FILL_FULL  = FILL_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] SAMPLE_MAX = '1;

  state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0]          w_addr_q, w_addr_d;
  logic [FILL_W-1:0]                 fill_q, fill_d;
  logic [TAP_IW-1:0]                 tap_idx_q, tap_idx_d;
  logic [DATA_WIDTH-1:0]             mic_q, mic_d;
  mode_t                             mode_q, mode_d;
  logic [NUM_TAPS-1:0]               en_q, en_d;
  logic [NUM_TAPS*ADDRESS_WIDTH-1:0] off_q, off_d;
  logic [NUM_TAPS*SHIFT_WIDTH-1:0]   shift_q, shift_d;
  logic [SHIFT_WIDTH-1:0]            fb_q, fb_d;
  logic [ACC_W-1:0]                  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]             tap0_q, tap0_d;
  logic                              rd_valid_q, rd_valid_d;
  logic [TAP_IW-1:0]                 rd_tap_q, rd_tap_d;
  logic                              rd_ok_q, rd_ok_d;
  logic [DATA_WIDTH-1:0]             dout_q, dout_d;
  logic                              out_valid_q, out_valid_d;
  logic                              overrun_q, overrun_d;

  logic                     accept;
  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [DATA_WIDTH-1:0]    tap_data;
  logic                     tap_ok;
  logic [ADDRESS_WIDTH-1:0] cur_off;
  logic [DATA_WIDTH-1:0]    result;
  logic [DATA_WIDTH-1:0]    wr_val;
  logic [DATA_WIDTH:0]      echo_sum;

  logic [ADDRESS_WIDTH-1:0] offs   [NUM_TAPS];
  logic [SHIFT_WIDTH-1:0]   shifts [NUM_TAPS];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid) state_d = READ;
      READ:    if (tap_idx_q == LAST_TAP) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy   = (state_q != IDLE);
    accept = (state_q == IDLE) && sample_valid;
    ram_we = (state_q == WRITE);
  end

  // Unpack the latched per-tap configuration.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      offs[k]   = off_q[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      shifts[k] = shift_q[k*SHIFT_WIDTH +: SHIFT_WIDTH];
    end
  end

  // Read address and validity of the tap issued this cycle. Offset 0 means
  // "DEPTH samples ago", which only exists once the buffer has filled.
  always_comb begin
    cur_off = offs[tap_idx_q];
    r_addr  = w_addr_q - cur_off;
    tap_ok  = ((cur_off != '0) && ({1'b0, cur_off} <= fill_q)) ||
              ((cur_off == '0) && (fill_q == FILL_FULL));
  end

  // Data returning from the RAM belongs to the tap issued one cycle earlier.
  assign tap_data = rd_ok_q ? rd_data : '0;

  // Result selection from the latched mode.
  always_comb begin
    echo_sum = {1'b0, mic_q} + {1'b0, tap0_q >> fb_q};
    result   = mic_q;
    wr_val   = mic_q;
    case (mode_q)
      DELAY:    result = tap0_q;
      MULTITAP: result = (acc_q > {{(ACC_W-DATA_WIDTH){1'b0}}, SAMPLE_MAX}) ?
                         SAMPLE_MAX : acc_q[DATA_WIDTH-1:0];
      ECHO: begin
        result = echo_sum[DATA_WIDTH] ? SAMPLE_MAX : echo_sum[DATA_WIDTH-1:0];
        wr_val = result;
      end
      BYPASS:   result = mic_q;
      default:  result = mic_q;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    w_addr_d    = w_addr_q;
    fill_d      = fill_q;
    tap_idx_d   = tap_idx_q;
    mic_d       = mic_q;
    mode_d      = mode_q;
    en_d        = en_q;
    off_d       = off_q;
    shift_d     = shift_q;
    fb_d        = fb_q;
    acc_d       = acc_q;
    tap0_d      = tap0_q;
    rd_valid_d  = (state_q == READ);
    rd_tap_d    = tap_idx_q;
    rd_ok_d     = tap_ok;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (accept) begin
      mic_d     = mic_signal;
      mode_d    = mode_t'(mode);
      en_d      = tap_en;
      off_d     = tap_offset;
      shift_d   = tap_shift;
      fb_d      = fb_shift;
      tap_idx_d = '0;
      acc_d     = '0;
      tap0_d    = '0;
    end

    if ((state_q == READ) && (tap_idx_q != LAST_TAP)) begin
      tap_idx_d = tap_idx_q + 1'b1;
    end

    if (rd_valid_q) begin
      if (rd_tap_q == '0) begin
        tap0_d = tap_data;
      end
      if (en_q[rd_tap_q]) begin
        acc_d = acc_q + ACC_W'(tap_data >> shifts[rd_tap_q]);
      end
    end

    if (state_q == WRITE) begin
      w_addr_d    = w_addr_q + 1'b1;
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      dout_d      = result;
      out_valid_d = 1'b1;
    end

    // A new overrun takes priority over a simultaneous clear.
    if (sample_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_addr_q    <= '0;
      fill_q      <= '0;
      tap_idx_q   <= '0;
      mic_q       <= '0;
      mode_q      <= DELAY;
      en_q        <= '0;
      off_q       <= '0;
      shift_q     <= '0;
      fb_q        <= '0;
      acc_q       <= '0;
      tap0_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_tap_q    <= '0;
      rd_ok_q     <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      w_addr_q    <= w_addr_d;
      fill_q      <= fill_d;
      tap_idx_q   <= tap_idx_d;
      mic_q       <= mic_d;
      mode_q      <= mode_d;
      en_q        <= en_d;
      off_q       <= off_d;
      shift_q     <= shift_d;
      fb_q        <= fb_d;
      acc_q       <= acc_d;
      tap0_q      <= tap0_d;
      rd_valid_q  <= rd_valid_d;
      rd_tap_q    <= rd_tap_d;
      rd_ok_q     <= rd_ok_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  dp_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (w_addr_q),
    .wr_data (wr_val),
    .rd_addr (r_addr),
    .rd_data (rd_data)
  );

  assign delayed_signal = dout_q;
  assign out_valid      = out_valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_echo_delay.sv
module tb_echo_delay;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int NT    = 4;
  localparam int DEPTH = 2**AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [DW-1:0]     mic_signal;
  logic [1:0]        mode;
  logic [NT-1:0]     tap_en;
  logic [NT*AW-1:0]  tap_offset;
  logic [NT*3-1:0]   tap_shift;
  logic [2:0]        fb_shift;
  logic              clr_overrun;
  logic [DW-1:0]     delayed_signal;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  echo_delay #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .mic_signal     (mic_signal),
    .mode           (mode),
    .tap_en         (tap_en),
    .tap_offset     (tap_offset),
    .tap_shift      (tap_shift),
    .fb_shift       (fb_shift),
    .clr_overrun    (clr_overrun),
    .delayed_signal (delayed_signal),
    .out_valid      (out_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  // Reference model: history of written samples, newest first.
  logic [DW-1:0] hist[$];

  // Configuration the driver applies on each strobe.
  logic [1:0]       cfg_mode;
  logic [NT-1:0]    cfg_en;
  logic [NT*AW-1:0] cfg_off;
  logic [NT*3-1:0]  cfg_sh;
  logic [2:0]       cfg_fb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample written d samples ago; 0 stands for DEPTH samples ago.
  function automatic logic [DW-1:0] tap_val(input int d);
    if (d != 0 && d <= hist.size()) return hist[d-1];
    if (d == 0 && hist.size() == DEPTH) return hist[DEPTH-1];
    return '0;
  endfunction

  task automatic model_step(input logic [DW-1:0] mic, output logic [DW-1:0] out);
    int sum;
    int o;
    int sh;
    logic [DW-1:0] wr;
    sum = 0;
    out = mic;
    wr  = mic;
    case (cfg_mode)
      2'd0: out = tap_val(int'(cfg_off[0 +: AW]));
      2'd1: begin
        for (int k = 0; k < NT; k++) begin
          if (cfg_en[k]) begin
            o   = int'(cfg_off[k*AW +: AW]);
            sh  = int'(cfg_sh[k*3 +: 3]);
            sum = sum + (int'(tap_val(o)) >> sh);
          end
        end
        out = (sum > 255) ? 8'd255 : DW'(sum);
      end
      2'd2: begin
        sum = int'(mic) + (int'(tap_val(int'(cfg_off[0 +: AW]))) >> int'(cfg_fb));
        out = (sum > 255) ? 8'd255 : DW'(sum);
        wr  = out;
      end
      default: out = mic;
    endcase
    hist.push_front(wr);
    if (hist.size() > DEPTH) void'(hist.pop_back());
  endtask

  // Called #1 after the edge that accepted mic.
  task automatic push_expected(input logic [DW-1:0] mic);
    logic [DW-1:0] out;
    model_step(mic, out);
    exp_q.push_back(out);
    exp_cyc_q.push_back(cyc + NT + 2);
  endtask

  task automatic set_off(input int k, input int v);
    cfg_off[k*AW +: AW] = AW'(v);
  endtask

  task automatic apply_cfg();
    mode       = cfg_mode;
    tap_en     = cfg_en;
    tap_offset = cfg_off;
    tap_shift  = cfg_sh;
    fb_shift   = cfg_fb;
  endtask

  // Garbage on the config inputs while a sample is in flight.
  task automatic scramble_cfg();
    mode       = 2'($urandom_range(0, 3));
    tap_en     = NT'($urandom_range(0, 15));
    tap_offset = {NT*AW{1'b0}} | (NT*AW)'({$urandom(), $urandom()});
    tap_shift  = 12'($urandom_range(0, 4095));
    fb_shift   = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("idle_wait_busy", busy, 0);
  endtask

  // Driver: call at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic send(input logic [DW-1:0] s);
    apply_cfg();
    mic_signal   = s;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    push_expected(s);
    scramble_cfg();
    mic_signal = DW'($urandom_range(0, 255));
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    hist.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("delayed_signal", delayed_signal, exp_q.pop_front());
        check("latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; sample_valid = 1'b0; clr_overrun = 1'b0; mic_signal = '0;
    mode = '0; tap_en = '0; tap_offset = '0; tap_shift = '0; fb_shift = '0;
    cfg_mode = 2'd0; cfg_en = '0; cfg_off = '0; cfg_sh = '0; cfg_fb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_delayed_signal", delayed_signal, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b1;

    // Plain delay by 4 samples.
    cfg_mode = 2'd0; cfg_off = '0; set_off(0, 4);
    for (int i = 1; i <= 10; i++) send(DW'(i));

    // Weighted multi-tap, then saturation.
    do_reset();
    cfg_mode = 2'd1; cfg_en = 4'b0011; cfg_off = '0; set_off(0, 1); set_off(1, 2);
    cfg_sh = '0; cfg_sh[3 +: 3] = 3'd1;
    for (int i = 0; i < 5; i++) send(8'd100);
    for (int i = 0; i < 5; i++) send(8'd200);

    // Feedback echo, impulse response.
    do_reset();
    cfg_mode = 2'd2; cfg_off = '0; set_off(0, 3); cfg_fb = 3'd1;
    send(8'd128);
    for (int i = 0; i < 9; i++) send(8'd0);

    // Overrun: back-to-back strobes, clear, and set-beats-clear.
    cfg_mode = 2'd0; cfg_off = '0; set_off(0, 1);
    apply_cfg(); mic_signal = 8'hA5; sample_valid = 1'b1;
    @(posedge clk); #1; push_expected(8'hA5);
    mic_signal = 8'h3C;
    @(posedge clk); #1; sample_valid = 1'b0;
    check("overrun_set", overrun, 1);
    check("busy_during_op", busy, 1);
    wait_idle();
    check("overrun_sticky", overrun, 1);
    clr_overrun = 1'b1; @(posedge clk); #1; clr_overrun = 1'b0;
    check("overrun_clr", overrun, 0);
    @(negedge clk);
    apply_cfg(); mic_signal = 8'h11; sample_valid = 1'b1;
    @(posedge clk); #1; push_expected(8'h11);
    mic_signal = 8'h22; clr_overrun = 1'b1;
    @(posedge clk); #1; sample_valid = 1'b0; clr_overrun = 1'b0;
    check("overrun_set_wins", overrun, 1);
    wait_idle();
    clr_overrun = 1'b1; @(posedge clk); #1; clr_overrun = 1'b0;
    @(negedge clk);
    send(8'h01);
    send(8'h02);

    // Randomized modes and configurations.
    for (int i = 0; i < 60; i++) begin
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_en   = NT'($urandom_range(0, 15));
      for (int k = 0; k < NT; k++) begin
        if ($urandom_range(0, 3) == 0) set_off(k, int'($urandom_range(0, DEPTH-1)));
        else set_off(k, int'($urandom_range(0, 8)));
      end
      cfg_sh = 12'($urandom_range(0, 4095));
      cfg_fb = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(DW'($urandom_range(0, 255)));
    end

    // Full-depth delay: offset 0 becomes live once the buffer wraps.
    do_reset();
    cfg_mode = 2'd0; cfg_off = '0;
    for (int k = 1; k < NT; k++) set_off(k, int'($urandom_range(1, 20)));
    for (int i = 0; i < DEPTH + 8; i++) send(DW'($urandom_range(1, 255)));

    // Reset while reading: sample discarded, no output.
    cfg_mode = 2'd0; cfg_off = '0; set_off(0, 4);
    apply_cfg(); mic_signal = 8'd77; sample_valid = 1'b1;
    @(posedge clk); #1; sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    rst = 1'b1;
    hist.delete();
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 10; i++) send(DW'(i));

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
